clkdiv_multi: RTL and testbench

Multi-channel, runtime-programmable clock divider and tick generator. It generalises the fixed single-output divider: each channel has its own divisor register, enable, and phase-aligned output. Divisor changes are glitch-free and take effect only at period boundaries, and a one-cycle tick strobe marks each period start. The block sits between the board oscillator and slow-rate consumers (display scan, debounce, seconds counter) so they can share one instance.

---
 rtl/clkdiv_multi.sv | 144 ++++++++++++++
 tb/tb_clkdiv_multi.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_multi.sv
// clkdiv_multi: multi-channel programmable clock divider / tick generator.
// Each lane owns its counter and divisor; the top only clamps and decodes
// the shared write port and fans out the shared sync strobe.

module clkdiv_lane #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] DIV_RST = WIDTH'(2)
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             wr_hit,
  input  logic [WIDTH-1:0] wr_val,
  output logic             clk_out,
  output logic             tick,
  output logic             pend
);
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] act_q, act_d;
  logic [WIDTH-1:0] pdiv_q, pdiv_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic [WIDTH-1:0] cnt_inc, lo_len;

  // Next-state: disabled lanes idle at cnt=0; enabled lanes sync > wrap > count.
  always_comb begin
    cnt_d   = cnt_q;
    act_d   = act_q;
    pdiv_d  = pdiv_q;
    pend_d  = pend_q;
    clk_d   = clk_q;
    tick_d  = 1'b0;
    cnt_inc = cnt_q + WIDTH'(1);
    // low phase is ceil(D/2) cycles, high phase floor(D/2)
    lo_len  = act_q - (act_q >> 1);
    if (!en) begin
      cnt_d = '0;
      clk_d = 1'b0;
      // nothing is running, so a write can take effect at once
      if (wr_hit) begin
        act_d  = wr_val;
        pend_d = 1'b0;
      end
    end else begin
      if (sync) begin
        cnt_d = '0;
        clk_d = 1'b0;
        if (pend_q) begin
          act_d  = pdiv_q;
          pend_d = 1'b0;
        end
      end else if (cnt_q >= act_q - WIDTH'(1)) begin
        // period boundary; >= also recovers from an out-of-range count
        cnt_d  = '0;
        clk_d  = 1'b0;
        tick_d = 1'b1;
        if (pend_q) begin
          act_d  = pdiv_q;
          pend_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_inc;
        clk_d = (cnt_inc >= lo_len);
      end
      // applied after the boundary logic so a same-cycle write waits a period
      if (wr_hit) begin
        pdiv_d = wr_val;
        pend_d = 1'b1;
      end
    end
  end

  // Lane state registers, outputs come straight from flops.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      act_q  <= DIV_RST;
      pdiv_q <= '0;
      pend_q <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      pdiv_q <= pdiv_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;
  assign pend    = pend_q;
endmodule

module clkdiv_multi #(
  parameter int          CH       = 4,
  parameter int          WIDTH    = 32,
  parameter int unsigned DIV_INIT = 50000000,
  localparam int         CW       = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [CW-1:0]    wr_ch,
  input  logic [WIDTH-1:0] wr_div,
  input  logic [CH-1:0]    en,
  input  logic             sync,
  output logic [CH-1:0]    clk_out,
  output logic [CH-1:0]    tick,
  output logic [CH-1:0]    pend
);
  localparam logic [WIDTH-1:0] DIV_RST =
    (DIV_INIT < 2) ? WIDTH'(2) : WIDTH'(DIV_INIT);

  logic [WIDTH-1:0] wr_val;
  logic [CH-1:0]    wr_hit;

  // Divisors below 2 have no meaningful waveform; force them to 2.
  assign wr_val = (wr_div < WIDTH'(2)) ? WIDTH'(2) : wr_div;

  for (genvar g = 0; g < CH; g++) begin : g_lane
    // out-of-range channel numbers match no lane and are dropped
    assign wr_hit[g] = wr_en && (32'(wr_ch) == 32'(g));

    clkdiv_lane #(
      .WIDTH   (WIDTH),
      .DIV_RST (DIV_RST)
    ) u_lane (
      .clk_in  (clk_in),
      .rst     (rst),
      .en      (en[g]),
      .sync    (sync),
      .wr_hit  (wr_hit[g]),
      .wr_val  (wr_val),
      .clk_out (clk_out[g]),
      .tick    (tick[g]),
      .pend    (pend[g])
    );
  end
endmodule

// File: tb/tb_clkdiv_multi.sv
// Directed bench for clkdiv_multi with CH=3 (so wr_ch=3 is out of range),
// WIDTH=16, DIV_INIT=4. Inputs change 1 time unit after the rising edge;
// outputs are checked at that same point.

module tb_clkdiv_multi;
  localparam int CH = 3;
  localparam int WIDTH = 16;

  logic             clk_in = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [1:0]       wr_ch;
  logic [WIDTH-1:0] wr_div;
  logic [CH-1:0]    en;
  logic             sync;
  logic [CH-1:0]    clk_out, tick, pend;

  int n_chk = 0;
  int n_err = 0;

  // D=4 from cnt=0: after edges 1..12
  bit p1_clk [12] = '{0,1,1,0, 0,1,1,0, 0,1,1,0};
  bit p1_tick[12] = '{0,0,0,1, 0,0,0,1, 0,0,0,1};
  // ch2 (D=2), ch1 (D=3) enabled together, edges 1..6, vector {ch2,ch1,ch0}
  logic [2:0] p2_clk [6] = '{3'b100, 3'b010, 3'b100, 3'b000, 3'b110, 3'b000};
  logic [2:0] p2_tick[6] = '{3'b000, 3'b100, 3'b010, 3'b100, 3'b000, 3'b110};
  // ch0 D=4 -> 6 written at cnt=1: edges 2..10
  bit p3_clk [9] = '{1,1,0, 0,0,1,1,1,0};
  bit p3_tick[9] = '{0,0,1, 0,0,0,0,0,1};
  bit p3_pend[9] = '{1,1,0, 0,0,0,0,0,0};
  // ch0 D=4, write 8 in wrap cycle: edges 4..16
  bit p4_clk [13] = '{0, 0,1,1,0, 0,0,0,1,1,1,1,0};
  bit p4_tick[13] = '{1, 0,0,0,1, 0,0,0,0,0,0,0,1};
  bit p4_pend[13] = '{1, 1,1,1,0, 0,0,0,0,0,0,0,0};
  // D=2 from cnt=0: edges 1..4
  bit p7_clk [4] = '{1,0,1,0};
  bit p7_tick[4] = '{0,1,0,1};

  clkdiv_multi #(.CH(CH), .WIDTH(WIDTH), .DIV_INIT(4)) dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_div  (wr_div),
    .en      (en),
    .sync    (sync),
    .clk_out (clk_out),
    .tick    (tick),
    .pend    (pend)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_div = '0; en = '0; sync = 1'b0;
    step(); step();
    chk("rst_clk", 32'(clk_out), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_pend", 32'(pend), 0);

    // DIV_INIT=4 on all channels
    rst = 1'b0; en = 3'b111;
    for (int k = 0; k < 12; k++) begin
      step();
      chk($sformatf("p1_clk%0d", k), 32'(clk_out), p1_clk[k] ? 32'h7 : 32'h0);
      chk($sformatf("p1_tick%0d", k), 32'(tick), p1_tick[k] ? 32'h7 : 32'h0);
      chk($sformatf("p1_pend%0d", k), 32'(pend), 0);
    end

    // D=3 on ch1, D=2 on ch2 written while disabled
    en = 3'b000; wr_en = 1'b1; wr_ch = 2'd1; wr_div = 16'd3;
    step();
    wr_ch = 2'd2; wr_div = 16'd2;
    step();
    wr_en = 1'b0;
    chk("p2_pend_dis", 32'(pend), 0);
    en = 3'b110;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("p2_clk%0d", k), 32'(clk_out), 32'(p2_clk[k]));
      chk($sformatf("p2_tick%0d", k), 32'(tick), 32'(p2_tick[k]));
    end

    // ch0 D=4, write 6 at cnt=1
    en = 3'b001;
    step();
    wr_en = 1'b1; wr_ch = 2'd0; wr_div = 16'd6;
    for (int k = 0; k < 9; k++) begin
      step();
      if (k == 0) wr_en = 1'b0;
      chk($sformatf("p3_clk%0d", k), 32'(clk_out[0]), 32'(p3_clk[k]));
      chk($sformatf("p3_tick%0d", k), 32'(tick[0]), 32'(p3_tick[k]));
      chk($sformatf("p3_pend%0d", k), 32'(pend[0]), 32'(p3_pend[k]));
    end

    // ch0 back to D=4, then write 8 exactly on the wrap edge
    en = 3'b000; wr_en = 1'b1; wr_ch = 2'd0; wr_div = 16'd4;
    step();
    wr_en = 1'b0; en = 3'b001;
    step(); step(); step();
    wr_en = 1'b1; wr_div = 16'd8;
    for (int k = 0; k < 13; k++) begin
      step();
      if (k == 0) wr_en = 1'b0;
      chk($sformatf("p4_clk%0d", k), 32'(clk_out[0]), 32'(p4_clk[k]));
      chk($sformatf("p4_tick%0d", k), 32'(tick[0]), 32'(p4_tick[k]));
      chk($sformatf("p4_pend%0d", k), 32'(pend[0]), 32'(p4_pend[k]));
    end

    // ch0/ch1 D=4 two cycles apart, then sync
    en = 3'b000; wr_en = 1'b1; wr_ch = 2'd0; wr_div = 16'd4;
    step();
    wr_ch = 2'd1;
    step();
    wr_en = 1'b0; en = 3'b001;
    step(); step();
    en = 3'b011;
    step(); step();
    chk("p5_pre_clk", 32'(clk_out), 32'h2);
    chk("p5_pre_tick", 32'(tick), 32'h1);
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("p5_sync_clk", 32'(clk_out), 0);
    chk("p5_sync_tick", 32'(tick), 0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("p5_clk%0d", k), 32'(clk_out), p1_clk[k] ? 32'h3 : 32'h0);
      chk($sformatf("p5_tick%0d", k), 32'(tick), p1_tick[k] ? 32'h3 : 32'h0);
    end

    // out-of-range channel: nothing changes
    wr_en = 1'b1; wr_ch = 2'd3; wr_div = 16'd2;
    step();
    wr_en = 1'b0;
    chk("p6_pend", 32'(pend), 0);
    for (int k = 1; k < 4; k++) begin
      step();
      chk($sformatf("p6_clk%0d", k), 32'(clk_out), p1_clk[k] ? 32'h3 : 32'h0);
      chk($sformatf("p6_tick%0d", k), 32'(tick), p1_tick[k] ? 32'h3 : 32'h0);
    end
    chk("p6_pend_end", 32'(pend), 0);

    // wr_div=0 clamps to 2
    en = 3'b000; wr_en = 1'b1; wr_ch = 2'd0; wr_div = 16'd0;
    step();
    wr_en = 1'b0; en = 3'b001;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("p7_clk%0d", k), 32'(clk_out[0]), 32'(p7_clk[k]));
      chk($sformatf("p7_tick%0d", k), 32'(tick[0]), 32'(p7_tick[k]));
    end

    // pending write, then async reset mid-cycle
    wr_en = 1'b1; wr_ch = 2'd0; wr_div = 16'd6;
    step();
    wr_en = 1'b0;
    chk("p8_pre_clk", 32'(clk_out[0]), 1);
    chk("p8_pre_pend", 32'(pend[0]), 1);
    #2 rst = 1'b1;
    #1;
    chk("p8_rst_clk", 32'(clk_out), 0);
    chk("p8_rst_tick", 32'(tick), 0);
    chk("p8_rst_pend", 32'(pend), 0);
    step(); step();
    rst = 1'b0; en = 3'b111;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("p8_clk%0d", k), 32'(clk_out), p1_clk[k] ? 32'h7 : 32'h0);
      chk($sformatf("p8_tick%0d", k), 32'(tick), p1_tick[k] ? 32'h7 : 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
